// File: rtl/fsm_pkg.sv
// Shared definitions for the serial-pattern FSM blocks: pattern limits,
// the reset-time default pattern, cycle classification and fill-width helper.
package fsm_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    // Default pattern, right-aligned; truncated to PAT_W by the user.
    localparam logic [PAT_W_MAX-1:0] DEFAULT_PATTERN = 16'h0006;

    // What a given clock edge does to the Moore state.
    typedef enum logic [1:0] {
        CYC_IDLE   = 2'd0,
        CYC_SAMPLE = 2'd1,
        CYC_LOAD   = 2'd2
    } cyc_kind_e;

    // Width needed for a fill counter that must reach pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with increment enable; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != CNT_MAX)) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/seq_detector_moore_p.sv
// Parametrised Moore serial-pattern detector with valid qualifier, run-time
// pattern reload, overlap/non-overlap mode and a saturating match counter.
module seq_detector_moore_p
    import fsm_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEFAULT_PATTERN),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    generate
        if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
            $error("seq_detector_moore_p: PAT_W out of range");
        end
    endgenerate

    logic [PAT_W-1:0]  hist_reg;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;
    logic [PAT_W-1:0]  pattern_reg;
    logic [PAT_W-1:0]  pattern_next;
    logic              z_reg;
    logic              z_next;

    cyc_kind_e         cyc_kind;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_adv;
    logic [PAT_W-1:0]  bit_eq;
    logic              match;

    // A load always wins; the bit presented alongside it is discarded.
    always_comb begin
        cyc_kind = CYC_IDLE;
        if (pat_load) begin
            cyc_kind = CYC_LOAD;
        end else if (x_valid) begin
            cyc_kind = CYC_SAMPLE;
        end
    end

    assign hist_shift = {hist_reg[PAT_W-2:0], x};
    assign fill_adv   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_bit_cmp
            assign bit_eq[gi] = ~(hist_shift[gi] ^ pattern_reg[gi]);
        end
    endgenerate

    // Matching on the post-shift state keeps z purely a function of registers.
    assign match = (cyc_kind == CYC_SAMPLE) && (fill_adv == FILL_FULL) && (&bit_eq);

    always_comb begin
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        pattern_next = pattern_reg;
        z_next       = z_reg;
        case (cyc_kind)
            CYC_LOAD: begin
                pattern_next = pat_in;
                hist_next    = '0;
                fill_next    = '0;
                z_next       = 1'b0;
            end
            CYC_SAMPLE: begin
                hist_next = hist_shift;
                fill_next = (match && !overlap_en) ? '0 : fill_adv;
                z_next    = match;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_reg    <= '0;
            fill_reg    <= '0;
            pattern_reg <= PAT_RST;
            z_reg       <= 1'b0;
        end else begin
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            pattern_reg <= pattern_next;
            z_reg       <= z_next;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .count (match_cnt)
    );

    assign z       = z_reg;
    assign pattern = pattern_reg;

endmodule

// File: tb/tb_seq_detector_moore_p.sv
// Bench for seq_detector_moore_p: directed steps plus random traffic, checked
// against a queue-based model of the detection rules; a CNT_W=2 copy shares the stream.
module tb_seq_detector_moore_p;

    localparam int PAT_W = 4;

    logic             clk;
    logic             reset;
    logic             x;
    logic             x_valid;
    logic             overlap_en;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             z;
    logic [7:0]       match_cnt;
    logic [PAT_W-1:0] pattern;
    logic             z2;
    logic [1:0]       match_cnt2;
    logic [PAT_W-1:0] pattern2;

    int checks = 0;
    int errors = 0;

    // Reference model state: bits sampled since the last clear, oldest first.
    bit               m_q[$];
    logic [PAT_W-1:0] m_pat;
    bit               m_z;
    int               m_cnt;

    seq_detector_moore_p #(
        .PAT_W   (PAT_W),
        .PAT_RST (4'b0110),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .x_valid    (x_valid),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .z          (z),
        .match_cnt  (match_cnt),
        .pattern    (pattern)
    );

    seq_detector_moore_p #(
        .PAT_W   (PAT_W),
        .PAT_RST (4'b0110),
        .CNT_W   (2)
    ) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .x_valid    (x_valid),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .z          (z2),
        .match_cnt  (match_cnt2),
        .pattern    (pattern2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pat = 4'b0110;
        m_z   = 1'b0;
        m_cnt = 0;
    endtask

    // Detection rule: the last PAT_W sampled bits (first-sent bit = pattern MSB).
    task automatic model_edge();
        bit hit;
        if (pat_load) begin
            m_pat = pat_in;
            m_q.delete();
            m_z = 1'b0;
        end else if (x_valid) begin
            m_q.push_back(x);
            if (m_q.size() > PAT_W) void'(m_q.pop_front());
            hit = (m_q.size() == PAT_W);
            for (int i = 0; i < PAT_W; i++) begin
                if (hit && (m_q[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
            end
            m_z = hit;
            if (hit) begin
                m_cnt++;
                if (!overlap_en) m_q.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        int e8;
        int e2;
        e8 = (m_cnt > 255) ? 255 : m_cnt;
        e2 = (m_cnt > 3) ? 3 : m_cnt;
        chk({tag, ".z"},       32'(z),          32'(m_z));
        chk({tag, ".cnt"},     32'(match_cnt),  32'(e8));
        chk({tag, ".pattern"}, 32'(pattern),    32'(m_pat));
        chk({tag, ".z_sat"},   32'(z2),         32'(m_z));
        chk({tag, ".cnt_sat"}, 32'(match_cnt2), 32'(e2));
    endtask

    // Called at a falling edge; drives one cycle and checks after the next rise.
    task automatic step(input string tag, input logic bx, input logic bv, input logic bov,
                        input logic bld, input logic [PAT_W-1:0] bpin);
        x          = bx;
        x_valid    = bv;
        overlap_en = bov;
        pat_load   = bld;
        pat_in     = bpin;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
        $display("%-8s x=%0b v=%0b ov=%0b ld=%0b pin=%b | z=%0b cnt=%0d cnt_sat=%0d pat=%b",
                 tag, bx, bv, bov, bld, bpin, z, match_cnt, match_cnt2, pattern);
    endtask

    task automatic send_bits(input string tag, input string s, input logic bov);
        for (int i = 0; i < s.len(); i++) begin
            step(tag, (s[i] == "1"), 1'b1, bov, 1'b0, 4'b0000);
        end
    endtask

    initial begin
        reset      = 1'b0;
        x          = 1'b0;
        x_valid    = 1'b0;
        overlap_en = 1'b1;
        pat_load   = 1'b0;
        pat_in     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b1;

        // Overlapping: 0110110 yields matches after bits 4 and 7.
        send_bits("ovl", "0110110", 1'b1);
        chk("ovl.total", 32'(match_cnt), 32'd2);

        // Non-overlapping: same stream gives one, then a fresh 0110 gives another.
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
        send_bits("novl", "0110110", 1'b0);
        send_bits("novl2", "0110", 1'b0);

        // Valid gaps hold state and never create a detection.
        step("clr", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110);
        send_bits("gap", "011", 1'b1);
        repeat (3) step("gap.idle", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        send_bits("gap", "0", 1'b1);

        // All-zero pattern: fill gating and load priority over x_valid.
        step("ld0", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        send_bits("zeros", "000", 1'b1);
        step("ldx", 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        send_bits("zeros", "0000", 1'b1);

        // Eight zeros with overlap: five matches, saturating the 2-bit counter.
        step("ld0", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        send_bits("sat", "00000000", 1'b1);

        // Asynchronous reset mid-cycle after a partial 011.
        step("ldp", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110);
        send_bits("pre", "011", 1'b1);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        check_all("arst.hold");
        reset = 1'b1;
        send_bits("post", "0", 1'b1);

        // Random traffic with occasional reloads and mode changes.
        for (int n = 0; n < 400; n++) begin
            logic rld;
            logic rv;
            logic rx;
            logic [PAT_W-1:0] rpin;
            if ((n % 25) == 0) overlap_en = 1'($urandom_range(0, 1));
            rld  = ($urandom_range(0, 31) == 0);
            rv   = ($urandom_range(0, 3) != 0);
            rx   = 1'($urandom_range(0, 1));
            rpin = 4'($urandom_range(0, 15));
            step("rand", rx, rv, overlap_en, rld, rpin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
